dmi_host_arbiter: RTL and testbench



---
 rtl/dmi_host_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dmi_host_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_host_arbiter.sv
// rtl/dmi_host_arbiter.sv - round-robin arbiter sharing one DMI-to-TL-UL host path
//
// Purpose: lets up to NumReq DMI-style requesters share a single
// tlul_adapter_host req/gnt/valid port. Only one transaction is ever in
// flight; its response is returned to the requester that issued it.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    per-requester request handshake (ready is one-hot or 0)
//   req_addr_i/we_i/wdata_i packed per-requester request payload
//   rsp_valid_o/ready_i    per-requester response handshake (valid is one-hot or 0)
//   rsp_data_o/err_o       shared response payload, qualified by rsp_valid_o
//   host_req_o/gnt_i       request side of the host adapter
//   host_addr_o/we_o/wdata_o request payload (byte address)
//   host_valid_i/rdata_i/err_i response side of the host adapter
//   busy_o, grant_idx_o    status: transaction in progress and its owner
module dmi_host_arbiter #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 7,
  parameter int TlAw      = 32,
  parameter int IdxW      = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]           req_we_i,
  input  logic [NumReq*32-1:0]        req_wdata_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [31:0]                 rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        host_req_o,
  input  logic                        host_gnt_i,
  output logic [TlAw-1:0]             host_addr_o,
  output logic                        host_we_o,
  output logic [31:0]                 host_wdata_o,
  input  logic                        host_valid_i,
  input  logic [31:0]                 host_rdata_i,
  input  logic                        host_err_i,
  output logic                        busy_o,
  output logic [IdxW-1:0]             grant_idx_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  // Round-robin pick: scan from last+1 and wrap, first valid requester wins.
  logic                 win_valid;
  logic [IdxW-1:0]      win_idx;
  logic [IdxW-1:0]      cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxW'((int'(last_q) + k) % NumReq);
      if (!win_valid && req_valid_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner payload mux and owner's response-ready select.
  logic [AddrWidth-1:0] sel_addr;
  logic                 sel_we;
  logic [31:0]          sel_wdata;
  logic                 owner_rsp_ready;

  always_comb begin
    sel_addr        = '0;
    sel_we          = 1'b0;
    sel_wdata       = '0;
    owner_rsp_ready = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (win_idx == IdxW'(i)) begin
        sel_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
        sel_we    = req_we_i[i];
        sel_wdata = req_wdata_i[i*32 +: 32];
      end
      if (owner_q == IdxW'(i)) begin
        owner_rsp_ready = rsp_ready_i[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    host_req_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A strobe raised during reset would be lost, so it is suppressed.
        if (win_valid && !rst_i) begin
          for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = (win_idx == IdxW'(i));
          end
          addr_d  = sel_addr;
          we_d    = sel_we;
          wdata_d = sel_wdata;
          owner_d = win_idx;
          last_d  = win_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        host_req_o = 1'b1;
        if (host_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (host_valid_i) begin
          rdata_d = host_rdata_i;
          err_d   = host_err_i;
          state_d = StResp;
        end
      end
      StResp: begin
        for (int i = 0; i < NumReq; i++) begin
          rsp_valid_o[i] = (owner_q == IdxW'(i));
        end
        if (owner_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NumReq - 1);
      owner_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign host_addr_o  = TlAw'({addr_q, 2'b00});
  assign host_we_o    = we_q;
  assign host_wdata_o = wdata_q;
  assign rsp_data_o   = rdata_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != StIdle);
  assign grant_idx_o  = owner_q;

endmodule

// File: tb/tb_dmi_host_arbiter.sv
// tb/tb_dmi_host_arbiter.sv - scoreboard bench for dmi_host_arbiter
module tb_dmi_host_arbiter;

  logic        clk;
  logic        rst_i;
  logic [1:0]  req_valid_i, req_ready_o, req_we_i;
  logic [13:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [1:0]  rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        host_req_o, host_gnt_i;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [31:0] host_wdata_o;
  logic        host_valid_i;
  logic [31:0] host_rdata_i;
  logic        host_err_i;
  logic        busy_o;
  logic [0:0]  grant_idx_o;

  dmi_host_arbiter #(.NumReq(2), .AddrWidth(7), .TlAw(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_wdata_o(host_wdata_o),
    .host_valid_i(host_valid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .busy_o(busy_o), .grant_idx_o(grant_idx_o)
  );

  typedef struct { logic [6:0] addr; logic we; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] baddr; logic we; logic [31:0] wdata;
                   int gdly; int vdly; logic [31:0] rdata; logic err; } host_t;
  typedef struct { int idx; logic [31:0] data; logic err; } rsp_t;

  req_t  rq0[$], rq1[$];
  host_t hq[$];
  rsp_t  sq[$];
  int    acc_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int acc_last = 0, acc_prev = 0, rsp_start = 0;
  logic [1:0] acc_mask = 2'b00;
  logic prev_rv = 1'b0;
  logic host_auto = 1'b1;
  int rsp_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push one transaction in the order it is expected to be accepted.
  task automatic push_x(input int r, input logic [6:0] a, input logic we, input logic [31:0] wd,
                        input int gd, input int vd, input logic [31:0] rd, input logic er);
    req_t q; host_t h; rsp_t s;
    q.addr = a; q.we = we; q.wdata = wd;
    if (r == 0) rq0.push_back(q); else rq1.push_back(q);
    h.baddr = {25'b0, a, 2'b00}; h.we = we; h.wdata = wd;
    h.gdly = gd; h.vdly = vd; h.rdata = rd; h.err = er;
    hq.push_back(h);
    s.idx = r; s.data = rd; s.err = er;
    sq.push_back(s);
    acc_q.push_back(r);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (k < 300 && !(rq0.size() == 0 && rq1.size() == 0 && hq.size() == 0 &&
                        acc_q.size() == 0 && sq.size() == 0 && !busy_o)) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", 64'(k >= 300), 64'(0));
  endtask

  task automatic wait_host_req();
    int k = 0;
    while (k < 20 && !host_req_o) begin
      tick(1);
      k++;
    end
    chk("host_req_timeout", 64'(host_req_o), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 0);
    chk({tag, "_rsp_data"}, 64'(rsp_data_o), 0);
    chk({tag, "_rsp_err"}, 64'(rsp_err_o), 0);
    chk({tag, "_host_req"}, 64'(host_req_o), 0);
    chk({tag, "_host_addr"}, 64'(host_addr_o), 0);
    chk({tag, "_host_we"}, 64'(host_we_o), 0);
    chk({tag, "_host_wdata"}, 64'(host_wdata_o), 0);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_grant_idx"}, 64'(grant_idx_o), 0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Requester driver: retire an accepted request, then present the next one.
  initial forever begin
    @(posedge clk);
    #1;
    if (acc_mask[0] && req_valid_i[0] && rq0.size() > 0) void'(rq0.pop_front());
    if (acc_mask[1] && req_valid_i[1] && rq1.size() > 0) void'(rq1.pop_front());
    req_valid_i[0] = (rq0.size() > 0);
    req_valid_i[1] = (rq1.size() > 0);
    if (rq0.size() > 0) begin
      req_addr_i[6:0] = rq0[0].addr; req_we_i[0] = rq0[0].we; req_wdata_i[31:0] = rq0[0].wdata;
    end
    if (rq1.size() > 0) begin
      req_addr_i[13:7] = rq1[0].addr; req_we_i[1] = rq1[0].we; req_wdata_i[63:32] = rq1[0].wdata;
    end
  end

  // Host adapter model: grant after gdly cycles of ISSUE, respond vdly cycles later.
  initial begin
    int hs = 0, cnt = 0;
    host_t cur;
    forever begin
      @(posedge clk);
      #1;
      if (!host_auto) begin
        hs = 0;
      end else begin
        host_gnt_i = 1'b0;
        host_valid_i = 1'b0;
        if (hs == 2) begin
          cnt++;
          if (cnt >= cur.vdly) begin
            host_valid_i = 1'b1; host_rdata_i = cur.rdata; host_err_i = cur.err;
            hs = 0;
          end
        end else begin
          if (hs == 0 && host_req_o) begin
            if (hq.size() == 0) chk("unexpected_host_req", 64'(host_req_o), 0);
            else begin
              cur = hq.pop_front(); hs = 1; cnt = 0;
            end
          end
          if (hs == 1) begin
            chk("host_req_hold", 64'(host_req_o), 1);
            chk("host_addr", 64'(host_addr_o), 64'(cur.baddr));
            chk("host_we", 64'(host_we_o), 64'(cur.we));
            chk("host_wdata", 64'(host_wdata_o), 64'(cur.wdata));
            if (cnt >= cur.gdly) begin
              host_gnt_i = 1'b1; hs = 2; cnt = 0;
            end else cnt++;
          end
        end
      end
    end
  end

  // Requester response side: optionally hold ready low for rsp_stall cycles,
  // raising ready on the non-owner meanwhile.
  initial begin
    int stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid_o != 2'b00) begin
        if (stall_cnt < rsp_stall) begin
          stall_cnt++;
          rsp_ready_i = ~rsp_valid_o;
        end else rsp_ready_i = rsp_valid_o;
      end else begin
        stall_cnt = 0;
        rsp_ready_i = 2'b00;
      end
    end
  end

  // Monitor: accepts and responses checked against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    acc_mask = req_ready_o;
    if (req_ready_o != 2'b00) begin
      chk("accept_while_busy", 64'(busy_o), 0);
      if (acc_q.size() == 0) chk("unexpected_accept", 64'(req_ready_o), 0);
      else chk("accept_idx", 64'(req_ready_o), 64'(oh(acc_q.pop_front())));
      acc_prev = acc_last;
      acc_last = cyc;
    end
    if (rsp_valid_o != 2'b00) begin
      if (!prev_rv) rsp_start = cyc;
      if (sq.size() == 0) chk("unexpected_rsp", 64'(rsp_valid_o), 0);
      else begin
        chk("rsp_valid", 64'(rsp_valid_o), 64'(oh(sq[0].idx)));
        chk("rsp_data", 64'(rsp_data_o), 64'(sq[0].data));
        chk("rsp_err", 64'(rsp_err_o), 64'(sq[0].err));
        chk("grant_idx", 64'(grant_idx_o), 64'(sq[0].idx));
        if ((rsp_valid_o & rsp_ready_i) != 2'b00) void'(sq.pop_front());
      end
    end
    prev_rv = (rsp_valid_o != 2'b00);
  end

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0;
    rsp_ready_i = '0; host_gnt_i = 1'b0; host_valid_i = 1'b0;
    host_rdata_i = '0; host_err_i = 1'b0;
    tick(2);
    chk_all_zero("reset");
    rst_i = 1'b0;
    tick(1);

    // Single read, gnt cycle 1, valid cycle 3 -> rsp_valid at cycle 4.
    push_x(0, 7'h05, 1'b0, 32'h0, 0, 2, 32'hCAFEF00D, 1'b0);
    wait_idle();
    chk("t1_acc_to_rsp", 64'(rsp_start - acc_last), 64'(4));

    // Both requesters continuously valid; last owner was 0 so 1 goes first.
    push_x(1, 7'h20, 1'b1, 32'h22222222, 0, 1, 32'hA1A1A1A1, 1'b0);
    push_x(0, 7'h10, 1'b1, 32'h11111111, 0, 1, 32'hA0A0A0A0, 1'b0);
    push_x(1, 7'h21, 1'b1, 32'h22222222, 1, 2, 32'hB1B1B1B1, 1'b0);
    push_x(0, 7'h11, 1'b1, 32'h11111111, 2, 1, 32'hB0B0B0B0, 1'b0);
    wait_idle();

    // Stalls: gnt after 5 cycles, response ready held low 4 cycles; req 0 waits.
    rsp_stall = 4;
    push_x(1, 7'h33, 1'b1, 32'hDEADBEEF, 5, 1, 32'h5A5A5A5A, 1'b0);
    push_x(0, 7'h44, 1'b0, 32'h0, 0, 1, 32'h12345678, 1'b0);
    wait_idle();
    rsp_stall = 0;

    // Best case: 3 cycles accept->response, 4 cycles accept->accept.
    push_x(1, 7'h01, 1'b0, 32'h0, 0, 1, 32'h00000001, 1'b0);
    push_x(1, 7'h02, 1'b0, 32'h0, 0, 1, 32'h00000002, 1'b0);
    wait_idle();
    chk("best_acc_to_acc", 64'(acc_last - acc_prev), 64'(4));
    chk("best_acc_to_rsp", 64'(rsp_start - acc_last), 64'(3));

    // Error response at the top word address.
    push_x(0, 7'h7F, 1'b0, 32'h0, 0, 1, 32'hFFFFFFFF, 1'b1);
    wait_idle();

    // Reset during WAIT from a requester-0 transaction, then a late valid.
    host_auto = 1'b0;
    begin
      req_t q;
      q.addr = 7'h01; q.we = 1'b0; q.wdata = 32'h0;
      rq0.push_back(q);
      acc_q.push_back(0);
    end
    wait_host_req();
    host_gnt_i = 1'b1;
    tick(1);
    host_gnt_i = 1'b0;
    chk("mid_busy_wait", 64'(busy_o), 1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    chk_all_zero("midrst");
    host_valid_i = 1'b1; host_rdata_i = 32'h99999999;
    tick(1);
    host_valid_i = 1'b0;
    tick(3);
    chk("late_valid_busy", 64'(busy_o), 0);
    chk("late_valid_data", 64'(rsp_data_o), 0);
    host_auto = 1'b1;
    push_x(0, 7'h0A, 1'b0, 32'h0, 0, 1, 32'h0A0A0A0A, 1'b0);
    push_x(1, 7'h0B, 1'b0, 32'h0, 0, 1, 32'h0B0B0B0B, 1'b0);
    wait_idle();

    // Stray host_valid in IDLE and stray gnt in WAIT.
    host_auto = 1'b0;
    host_valid_i = 1'b1; host_rdata_i = 32'h77777777;
    tick(1);
    host_valid_i = 1'b0;
    chk("stray_valid_busy", 64'(busy_o), 0);
    tick(1);
    chk("stray_valid_rsp", 64'(rsp_valid_o), 0);
    begin
      req_t q; rsp_t s;
      q.addr = 7'h0C; q.we = 1'b1; q.wdata = 32'hC0FFEE00;
      rq1.push_back(q);
      acc_q.push_back(1);
      s.idx = 1; s.data = 32'h0BADCAFE; s.err = 1'b0;
      sq.push_back(s);
    end
    wait_host_req();
    chk("stray_host_addr", 64'(host_addr_o), 64'h30);
    host_gnt_i = 1'b1;
    tick(1);
    host_gnt_i = 1'b0;
    host_gnt_i = 1'b1;
    tick(1);
    host_gnt_i = 1'b0;
    chk("stray_gnt_busy", 64'(busy_o), 1);
    chk("stray_gnt_host_req", 64'(host_req_o), 0);
    chk("stray_gnt_rsp", 64'(rsp_valid_o), 0);
    host_valid_i = 1'b1; host_rdata_i = 32'h0BADCAFE; host_err_i = 1'b0;
    tick(1);
    host_valid_i = 1'b0;
    wait_idle();
    host_auto = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
